rb_wr_ctrl: RTL and testbench

Write/read controller for the four-row NIP row buffer held in one 32-bit-wide BRAM, with each image row in one byte lane. It accepts a raster pixel stream and generates the BRAM address, byte write enables and replicated write data. It also drives the lane-rotation select and enable of the downstream steering stage, so that the stage's four outputs always present rows newest-to-oldest. The block sits directly upstream of the steering stage and the 3x3 window logic.

---
 rtl/rb_wr_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rb_wr_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_wr_ctrl.sv
// rb_wr_ctrl: write/read controller for the four-row NIP row buffer.
// One 32-bit BRAM holds four image rows, one row per byte lane. This block
// turns a raster pixel stream into BRAM address / byte enables / replicated
// data. It also drives the lane-rotation select of the downstream steering
// stage, so that the stage presents rows newest-to-oldest.
// Optional feature macro: RB_EOL_EN (adds win_eol / win_eof and a row counter).
module rb_wr_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout,
    output logic              steer_en,
    output logic [1:0]        steer_sel,
    output logic [7:0]        pix_d,
`ifdef RB_EOL_EN
    output logic              win_eol,
    output logic              win_eof,
`endif
    output logic              win_valid
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] col_reg, col_next, col_eff;
    logic [1:0]        lane_reg, lane_next, lane_eff;
    logic [1:0]        fill_reg, fill_next, fill_eff;
    logic              ready_reg;
    logic              accept, take, last_col, run_pix;
    logic [3:0]        we_lane;
    logic [1:0]        sel_lane;
    logic [31:0]       din_rep;

    // Stage-1 side information travelling alongside the BRAM write
    logic              s1_valid_reg;
    logic [1:0]        s1_sel_reg;
    logic [7:0]        s1_pix_reg;
    logic              s1_win_reg;

    // Read data is consumed downstream; this block only aligns to it
    logic              dout_unused;
    assign dout_unused = ^bram_dout;

    assign pix_ready = ready_reg;
    assign accept    = pix_valid & ready_reg;

    // Replicate the pixel onto all four byte lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rep
            assign din_rep[8*gi +: 8] = pix_in;
        end
    endgenerate

`ifdef RB_EOL_EN
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    logic [ROW_W-1:0] row_reg, row_next, row_eff;
    logic             row_last;
    logic             s1_eol_reg, s1_eof_reg;
`else
    localparam int unused_height = IMG_HEIGHT;
`endif

    // Next-state, counter advance and per-pixel lane decode
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        lane_next  = lane_reg;
        fill_next  = fill_reg;
        // a sof pixel restarts the frame on itself
        col_eff    = pix_sof ? '0   : col_reg;
        lane_eff   = pix_sof ? 2'd0 : lane_reg;
        fill_eff   = pix_sof ? 2'd0 : fill_reg;
        take       = accept & (pix_sof | (state_reg != IDLE));
        last_col   = (col_eff == LAST_COL);
        run_pix    = (state_reg == RUN) & ~pix_sof;
        sel_lane   = 2'd0 - lane_eff;
        unique case (lane_eff)
            2'd0:    we_lane = 4'b0001;
            2'd1:    we_lane = 4'b1000;
            2'd2:    we_lane = 4'b0100;
            default: we_lane = 4'b0010;
        endcase
        if (take) begin
            col_next   = last_col ? '0 : col_eff + 1'b1;
            lane_next  = last_col ? lane_eff + 2'd1 : lane_eff;
            fill_next  = (last_col && fill_eff != 2'd3) ? fill_eff + 2'd1 : fill_eff;
            state_next = (fill_next == 2'd3) ? RUN : FILL;
        end
    end

`ifdef RB_EOL_EN
    // Row position within the frame; wraps silently past the last row
    always_comb begin
        row_eff  = pix_sof ? '0 : row_reg;
        row_last = (row_eff == LAST_ROW);
        row_next = row_reg;
        if (take) begin
            if (last_col) begin
                row_next = row_last ? '0 : row_eff + 1'b1;
            end else begin
                row_next = row_eff;
            end
        end
    end

    // Row counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg <= '0;
        end else begin
            row_reg <= row_next;
        end
    end
`endif

    // FSM state and position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            lane_reg  <= 2'd0;
            fill_reg  <= 2'd0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            lane_reg  <= lane_next;
            fill_reg  <= fill_next;
            ready_reg <= 1'b1;
        end
    end

    // Stage 1: BRAM write port plus side data waiting for the read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr    <= '0;
            bram_we      <= 4'b0;
            bram_din     <= 32'b0;
            s1_valid_reg <= 1'b0;
            s1_sel_reg   <= 2'd0;
            s1_pix_reg   <= 8'd0;
            s1_win_reg   <= 1'b0;
`ifdef RB_EOL_EN
            s1_eol_reg   <= 1'b0;
            s1_eof_reg   <= 1'b0;
`endif
        end else begin
            s1_valid_reg <= take;
            bram_we      <= take ? we_lane : 4'b0;
            if (take) begin
                bram_addr  <= col_eff;
                bram_din   <= din_rep;
                s1_sel_reg <= sel_lane;
                s1_pix_reg <= pix_in;
                s1_win_reg <= run_pix;
`ifdef RB_EOL_EN
                s1_eol_reg <= last_col;
                s1_eof_reg <= last_col & row_last;
`endif
            end
        end
    end

    // Stage 2: steering controls aligned with bram_dout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steer_en  <= 1'b0;
            steer_sel <= 2'd0;
            pix_d     <= 8'd0;
            win_valid <= 1'b0;
`ifdef RB_EOL_EN
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
`endif
        end else begin
            steer_en  <= s1_valid_reg;
            win_valid <= s1_valid_reg & s1_win_reg;
`ifdef RB_EOL_EN
            win_eol   <= s1_valid_reg & s1_eol_reg;
            win_eof   <= s1_valid_reg & s1_eof_reg;
`endif
            if (s1_valid_reg) begin
                steer_sel <= s1_sel_reg;
                pix_d     <= s1_pix_reg;
            end
        end
    end

endmodule

// File: tb/tb_rb_wr_ctrl.sv
// Testbench for rb_wr_ctrl: random pixel stream, frame-position reference
// model feeding two scoreboards (BRAM write port, steering outputs).
module tb_rb_wr_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_ready;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout;
    logic          steer_en;
    logic [1:0]    steer_sel;
    logic [7:0]    pix_d;
    logic          win_valid;
`ifdef RB_EOL_EN
    logic          win_eol;
    logic          win_eof;
`endif

    rb_wr_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .bram_addr(bram_addr),
        .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
        .steer_en(steer_en), .steer_sel(steer_sel), .pix_d(pix_d),
`ifdef RB_EOL_EN
        .win_eol(win_eol), .win_eof(win_eof),
`endif
        .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        int          addr;
        logic [3:0]  we;
        logic [31:0] din;
    } wr_t;

    typedef struct {
        int         stamp;
        logic [1:0] sel;
        logic [7:0] pix;
        logic       win;
        logic       eol;
        logic       eof;
    } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  vectors = 0;
    int  miscompares = 0;

    // reference model state: position since the last sof
    bit  in_frame = 0;
    int  pcount = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, 32'(bram_addr), 32'd0);
        chk({tag, "_we"}, 32'(bram_we), 32'd0);
        chk({tag, "_din"}, bram_din, 32'd0);
        chk({tag, "_steer_en"}, 32'(steer_en), 32'd0);
        chk({tag, "_steer_sel"}, 32'(steer_sel), 32'd0);
        chk({tag, "_pix_d"}, 32'(pix_d), 32'd0);
        chk({tag, "_win_valid"}, 32'(win_valid), 32'd0);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
`ifdef RB_EOL_EN
        chk({tag, "_win_eol"}, 32'(win_eol), 32'd0);
        chk({tag, "_win_eof"}, 32'(win_eof), 32'd0);
`endif
    endtask

    // Drive one cycle of input and record what the block must produce
    task automatic send(input bit v, input bit s, input logic [7:0] d);
        wr_t w;
        st_t t;
        int  row, col, lane;
        logic [3:0] lane_we [4];
        lane_we[0] = 4'b0001; lane_we[1] = 4'b1000;
        lane_we[2] = 4'b0100; lane_we[3] = 4'b0010;
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_sof   = s;
        pix_in    = d;
        if (v) begin
            if (s) begin
                in_frame = 1;
                pcount   = 0;
            end
            if (in_frame) begin
                row  = pcount / W;
                col  = pcount % W;
                lane = row % 4;
                w.stamp = cyc; w.addr = col; w.we = lane_we[lane]; w.din = {4{d}};
                t.stamp = cyc; t.sel = 2'((4 - lane) % 4); t.pix = d;
                t.win   = (row >= 3);
                t.eol   = (col == W - 1);
                t.eof   = (col == W - 1) && ((row % H) == H - 1);
                wq.push_back(w);
                sq.push_back(t);
                pcount++;
            end
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        #1;
        check_reset("midrst");
        wq.delete();
        sq.delete();
        in_frame = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pop and compare whenever the DUT presents an output
    wr_t we_e;
    st_t st_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we != 4'b0) begin
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected cyc=%0d got we=%b addr=%0d exp no write", cyc, bram_we, bram_addr);
                end else begin
                    we_e = wq.pop_front();
                    if (cyc != we_e.stamp + 1 || int'(bram_addr) != we_e.addr ||
                        bram_we != we_e.we || bram_din != we_e.din) begin
                        miscompares++;
                        $display("FAIL wr cyc=%0d got addr=%0d we=%b din=%h exp cyc=%0d addr=%0d we=%b din=%h",
                                 cyc, bram_addr, bram_we, bram_din, we_e.stamp + 1, we_e.addr, we_e.we, we_e.din);
                    end
                end
            end else if (wq.size() > 0 && wq[0].stamp + 1 <= cyc) begin
                vectors++;
                miscompares++;
                we_e = wq.pop_front();
                $display("FAIL wr_missing cyc=%0d got we=0 exp addr=%0d we=%b", cyc, we_e.addr, we_e.we);
            end

            if (steer_en) begin
                vectors++;
                if (sq.size() == 0) begin
                    miscompares++;
                    $display("FAIL steer_unexpected cyc=%0d got steer_en=1 exp 0", cyc);
                end else begin
                    st_e = sq.pop_front();
                    if (cyc != st_e.stamp + 2 || steer_sel != st_e.sel ||
                        pix_d != st_e.pix || win_valid != st_e.win) begin
                        miscompares++;
                        $display("FAIL steer cyc=%0d got sel=%0d pix=%h win=%b exp cyc=%0d sel=%0d pix=%h win=%b",
                                 cyc, steer_sel, pix_d, win_valid, st_e.stamp + 2, st_e.sel, st_e.pix, st_e.win);
                    end
`ifdef RB_EOL_EN
                    if (win_eol != st_e.eol || win_eof != st_e.eof) begin
                        miscompares++;
                        $display("FAIL eol_eof cyc=%0d got eol=%b eof=%b exp eol=%b eof=%b",
                                 cyc, win_eol, win_eof, st_e.eol, st_e.eof);
                    end
`endif
                end
            end else begin
                if (win_valid) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL win_without_en cyc=%0d got win_valid=1 exp 0", cyc);
                end
                if (sq.size() > 0 && sq[0].stamp + 2 <= cyc) begin
                    vectors++;
                    miscompares++;
                    st_e = sq.pop_front();
                    $display("FAIL steer_missing cyc=%0d got steer_en=0 exp sel=%0d pix=%h", cyc, st_e.sel, st_e.pix);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_in = 8'd0;
        bram_dout = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(pix_ready), 32'd1);

        // pixels before any sof are dropped
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 8'($urandom));

        // first frame: sof pixel 0x11 then 15 back-to-back pixels
        send(1'b1, 1'b1, 8'h11);
        for (int i = 0; i < 15; i++) send(1'b1, 1'b0, 8'($urandom));

        // valid toggling in RUN
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0, 8'($urandom));
            send(1'b0, 1'b0, 8'($urandom));
        end

        // random stream with occasional sof and gaps
        for (int i = 0; i < 300; i++)
            send(($urandom % 4) != 0, ($urandom % 40) == 0, 8'($urandom));

        // sof at col 2 of row 5, then refill
        send(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 21; i++) send(1'b1, 1'b0, 8'($urandom));
        send(1'b1, 1'b1, 8'h5a);
        for (int i = 0; i < 17; i++) send(1'b1, 1'b0, 8'($urandom));

        // reset asserted during row 4 in RUN, then a fresh frame
        send(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 17; i++) send(1'b1, 1'b0, 8'($urandom));
        mid_reset();
        send(1'b1, 1'b1, 8'h33);
        for (int i = 0; i < 19; i++) send(1'b1, 1'b0, 8'($urandom));

        // drain the pipeline
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 8'd0);
        #1;
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);
        chk("steer_queue_empty", 32'(sq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
